// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_W = 4;

    // Quotient reported for a zero divisor at the default width.
    localparam logic [DEF_W-1:0] DBZ_Q = '1;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO: DEPTH entries of DW bits. Full/empty are derived from a registered count.
module div_req_fifo #(
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CNTW'(1);
            else if (!do_push && do_pop) count <= count - CNTW'(1);
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Front-end for a combinational divider core: queues requests, issues them one at a time,
// waits for the core to settle and returns tagged results. Zero divisors bypass the core.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 2,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic [W-1:0]     core_x,
    output logic [W-1:0]     core_y,
    input  logic [W-1:0]     core_q,
    input  logic [W:0]       core_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_q,
    output logic [W-1:0]     out_r,
    output logic             out_dbz,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned DW = 2 * W + TAG_W;
    localparam int unsigned CW = $clog2(CORE_LAT + 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0]    cur_tag;

    logic                fifo_full, fifo_empty, fifo_pop;
    logic [DW-1:0]       fifo_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [W-1:0]        f_x, f_y;
    logic [TAG_W-1:0]    f_tag;

    logic                issue, load_core, load_dbz, load_res, clr_valid;

    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign {f_x, f_y, f_tag} = fifo_data;

    div_req_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data ({in_x, in_y, in_tag}),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and datapath strobes; an accepted result in DONE can issue the next request at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        load_core = 1'b0;
        load_dbz  = 1'b0;
        load_res  = 1'b0;
        clr_valid = 1'b0;
        issue     = !fifo_empty && ((state_q == IDLE) || (state_q == DONE && out_ready));
        if (issue) begin
            fifo_pop = 1'b1;
            if (f_y != '0) begin
                load_core = 1'b1;
                cnt_d     = CW'(CORE_LAT);
                state_d   = WAIT;
            end else begin
                load_dbz = 1'b1;
                state_d  = DONE;
            end
        end else begin
            case (state_q)
                WAIT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        load_res = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        clr_valid = 1'b1;
                        state_d   = IDLE;
                    end
                end
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Core operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_x    <= '0;
            core_y    <= '0;
            cur_tag   <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_dbz   <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (load_core) begin
                core_x    <= f_x;
                core_y    <= f_y;
                cur_tag   <= f_tag;
                out_valid <= 1'b0;
            end
            if (load_dbz) begin
                out_q     <= '1;
                out_r     <= f_x;
                out_dbz   <= 1'b1;
                out_tag   <= f_tag;
                out_valid <= 1'b1;
            end
            if (load_res) begin
                out_q     <= core_q;
                out_r     <= core_r[W-1:0];
                out_dbz   <= 1'b0;
                out_tag   <= cur_tag;
                out_valid <= 1'b1;
            end
            if (clr_valid) out_valid <= 1'b0;
        end
    end

    // A legal remainder never sets its top bit; flag a misbehaving core.
    always_ff @(posedge clk) begin
        if (rst_n && load_res) begin
            assert (!core_r[W]) else $error("core remainder bit W set");
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with an ideal combinational divider and a queue-based result model.
module tb_div_issue_ctrl;

    localparam int unsigned W     = 4;
    localparam int unsigned TAG_W = 2;

    typedef struct packed {
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [W-1:0]     q;
        logic [W-1:0]     r;
        logic             dbz;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_x = '0;
    logic [W-1:0]     in_y = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [W-1:0]     core_x, core_y, core_q;
    logic [W:0]       core_r;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_q, out_r;
    logic             out_dbz;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc = 0;
    int   n_res = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    req_t pend[$];
    res_t model[$];
    res_t got[$];
    int   hs_cyc[$];
    res_t last;
    bit   prev_stall = 0;
    res_t stall_v;

    always #5 clk = ~clk;

    // Ideal divider core; settles within one cycle.
    always_comb begin
        core_q = '0;
        core_r = '0;
        if (core_y != '0) begin
            core_q = core_x / core_y;
            core_r = {1'b0, core_x % core_y};
        end
    end

    div_issue_ctrl #(
        .W        (W),
        .DEPTH    (4),
        .TAG_W    (TAG_W),
        .CORE_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .core_x    (core_x),
        .core_y    (core_y),
        .core_q    (core_q),
        .core_r    (core_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dbz   (out_dbz),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    function automatic res_t predict(input req_t rq);
        res_t e;
        e.tag = rq.tag;
        if (rq.y == 0) begin
            e.q   = 4'hF;
            e.r   = rq.x;
            e.dbz = 1'b1;
        end else begin
            e.q   = rq.x / rq.y;
            e.r   = rq.x % rq.y;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_req(input int x, input int y, input int tag);
        req_t rq;
        rq.x   = W'(x);
        rq.y   = W'(y);
        rq.tag = TAG_W'(tag);
        pend.push_back(rq);
    endtask

    task automatic drive();
        in_valid = (pend.size() != 0);
        if (pend.size() != 0) begin
            in_x   = pend[0].x;
            in_y   = pend[0].y;
            in_tag = pend[0].tag;
        end
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Called at a falling edge: score what the next rising edge will do, advance one cycle, re-drive.
    task automatic tick();
        bit   acc;
        res_t e;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_out", 32'({out_q, out_r, out_dbz, out_tag}), 32'(stall_v));
        end
        prev_stall = out_valid && !out_ready;
        stall_v    = {out_q, out_r, out_dbz, out_tag};
        acc = in_valid && in_ready;
        if (acc) begin
            model.push_back(predict({in_x, in_y, in_tag}));
            n_acc++;
        end
        if (out_valid && out_ready) begin
            if (model.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                e = model.pop_front();
                chk("res_q", 32'(out_q), 32'(e.q));
                chk("res_r", 32'(out_r), 32'(e.r));
                chk("res_dbz", 32'(out_dbz), 32'(e.dbz));
                chk("res_tag", 32'(out_tag), 32'(e.tag));
            end
            last = {out_q, out_r, out_dbz, out_tag};
            got.push_back(last);
            hs_cyc.push_back(cyc);
            n_res++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (acc) void'(pend.pop_front());
        drive();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((pend.size() != 0 || model.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(pend.size() + model.size()), 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
    endtask

    initial begin
        int n, a0, r0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({out_q, out_r, out_dbz, out_tag}), 0);
        chk("rst_core", 32'({core_x, core_y}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single divide: result three cycles after the request is presented.
        ready_mode = 1;
        add_req(13, 3, 1);
        drive();
        wait_valid(n);
        chk("lat_div", 32'(n), 3);
        tick();
        chk("div_res", 32'(last), 32'(res_t'{4'd4, 4'd1, 1'b0, 2'd1}));
        chk("div_core", 32'({core_x, core_y}), 32'({4'd13, 4'd3}));
        chk("div_busy", 32'(busy), 0);

        // Divide by zero: two cycles, core operands untouched.
        add_req(7, 0, 2);
        drive();
        wait_valid(n);
        chk("lat_dbz", 32'(n), 2);
        tick();
        chk("dbz_res", 32'(last), 32'(res_t'{4'hF, 4'd7, 1'b1, 2'd2}));
        chk("dbz_core", 32'({core_x, core_y}), 32'({4'd13, 4'd3}));

        // Capacity under backpressure: FIFO depth plus one in flight.
        ready_mode = 0;
        a0 = n_acc;
        r0 = n_res;
        for (int i = 0; i < 6; i++) add_req(i + 1, 1, i);
        drive();
        repeat (10) tick();
        chk("cap_accepted", 32'(n_acc - a0), 5);
        chk("cap_in_ready", 32'(in_ready), 0);
        chk("cap_pending", 32'(pend.size()), 1);
        ready_mode = 1;
        drive();
        drain(200);
        chk("cap_results", 32'(n_res - r0), 6);

        // Back-to-back stream.
        got.delete();
        hs_cyc.delete();
        add_req(15, 1, 0);
        add_req(0, 5, 1);
        add_req(9, 9, 2);
        add_req(14, 4, 3);
        drive();
        drain(100);
        chk("stream_busy_fall", 32'(busy), 0);
        chk("stream_count", 32'(got.size()), 4);
        if (got.size() == 4) begin
            chk("stream_0", 32'({got[0].q, got[0].r}), 32'({4'd15, 4'd0}));
            chk("stream_1", 32'({got[1].q, got[1].r}), 32'({4'd0, 4'd0}));
            chk("stream_2", 32'({got[2].q, got[2].r}), 32'({4'd1, 4'd0}));
            chk("stream_3", 32'({got[3].q, got[3].r}), 32'({4'd3, 4'd2}));
            for (int i = 1; i < 4; i++) chk("stream_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 2);
        end

        // Toggled out_ready: stalls hold outputs, nothing lost or duplicated.
        ready_mode = 2;
        r0 = n_res;
        for (int i = 0; i < 8; i++) add_req($urandom_range(0, 15), $urandom_range(0, 15), i);
        drive();
        drain(300);
        chk("toggle_results", 32'(n_res - r0), 8);

        // Reset while a request is in WAIT with three queued behind it.
        ready_mode = 0;
        for (int i = 0; i < 5; i++) add_req(i + 8, 2, i);
        drive();
        repeat (5) tick();
        chk("pre_rst_pending", 32'(pend.size()), 0);
        ready_mode = 1;
        drive();
        tick();
        chk("pre_rst_wait", 32'({out_valid, busy}), 32'(2'b01));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        model.delete();
        pend.delete();
        prev_stall = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_req(6, 4, 3);
        drive();
        drain(50);
        chk("post_rst_res", 32'(last), 32'(res_t'{4'd1, 4'd2, 1'b0, 2'd3}));

        // Random traffic with random backpressure.
        ready_mode = 3;
        r0 = n_res;
        for (int i = 0; i < 40; i++) begin
            add_req($urandom_range(0, 15),
                    ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15),
                    $urandom_range(0, 3));
        end
        drive();
        drain(2000);
        chk("rand_results", 32'(n_res - r0), 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
